// File: rtl/mbc_pkg.sv
// -----------------------------------------------------------------------------
// mbc_pkg
// Shared definitions for the basic-computer control unit: controller state
// encoding, ALU operation codes, memory-reference opcodes, register-reference
// instruction bit positions and small dispatch helpers.
// Optional feature used by the importing files: MBC_INDIRECT_EN (adds INDIR).
// -----------------------------------------------------------------------------
package mbc_pkg;

    // Controller states
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_INDIR  = 3'd2,
        ST_OPRD   = 3'd3,
        ST_EXEC   = 3'd4,
        ST_WRITE  = 3'd5,
        ST_REGREF = 3'd6,
        ST_HALT   = 3'd7
    } state_e;

    // ALU operation select codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_ADD  = 4'b0001;
    localparam logic [3:0] ALU_LDA  = 4'b0010;
    localparam logic [3:0] ALU_CMA  = 4'b0011;
    localparam logic [3:0] ALU_CIR  = 4'b0100;
    localparam logic [3:0] ALU_CIL  = 4'b0101;
    localparam logic [3:0] ALU_CLA  = 4'b0110;
    localparam logic [3:0] ALU_INC  = 4'b0111;
    localparam logic [3:0] ALU_CLE  = 4'b1000;
    localparam logic [3:0] ALU_CME  = 4'b1001;
    localparam logic [3:0] ALU_SPA  = 4'b1010;
    localparam logic [3:0] ALU_SNA  = 4'b1011;
    localparam logic [3:0] ALU_SZA  = 4'b1100;
    localparam logic [3:0] ALU_SZE  = 4'b1101;
    localparam logic [3:0] ALU_NONE = 4'b1111;

    // Opcode field IR[14:12]
    localparam logic [2:0] OP_AND = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STA = 3'd3;
    localparam logic [2:0] OP_BUN = 3'd4;
    localparam logic [2:0] OP_BSA = 3'd5;
    localparam logic [2:0] OP_ISZ = 3'd6;
    localparam logic [2:0] OP_REG = 3'd7;

    // Register-reference bit positions within IR[11:0] (bit 11 has priority)
    localparam int RR_CLA = 11;
    localparam int RR_CLE = 10;
    localparam int RR_CMA = 9;
    localparam int RR_CME = 8;
    localparam int RR_CIR = 7;
    localparam int RR_CIL = 6;
    localparam int RR_INC = 5;
    localparam int RR_SPA = 4;
    localparam int RR_SNA = 3;
    localparam int RR_SZA = 2;
    localparam int RR_SZE = 1;
    localparam int RR_HLT = 0;

    // Where a memory-reference instruction goes once its effective address is
    // known. BUN and ISZ both return to FETCH (BUN's pc load is done by caller).
    function automatic state_e mref_next(input logic [2:0] op);
        state_e nxt;
        case (op)
            OP_AND, OP_ADD, OP_LDA: nxt = ST_OPRD;
            OP_STA, OP_BSA:         nxt = ST_WRITE;
            default:                nxt = ST_FETCH;
        endcase
        return nxt;
    endfunction

    // States that hold a memory read request
    function automatic logic is_read_state(input state_e s);
        return (s == ST_FETCH) || (s == ST_INDIR) || (s == ST_OPRD);
    endfunction

endpackage

// File: rtl/mbc_regref_decode.sv
// -----------------------------------------------------------------------------
// mbc_regref_decode
// Combinational decode of a register-reference instruction. Only the highest
// set bit of IR[11:0] is honoured (bit 11 highest); IR[11:0]=0 is a NOP.
// Ports:
//   ir_low   in  12  IR[11:0]
//   alu_code out 4   ALU operation (1111 when none)
//   ac_ld    out 1   accumulator load strobe
//   e_ld     out 1   E flag load strobe
//   skip     out 1   skip-type operation (pc advances if ALU flags condition)
//   hlt      out 1   halt instruction
// -----------------------------------------------------------------------------
module mbc_regref_decode
    import mbc_pkg::*;
(
    input  logic [11:0] ir_low,
    output logic [3:0]  alu_code,
    output logic        ac_ld,
    output logic        e_ld,
    output logic        skip,
    output logic        hlt
);

    // Priority decode of the register-reference operation
    always_comb begin
        alu_code = ALU_NONE;
        ac_ld    = 1'b0;
        e_ld     = 1'b0;
        skip     = 1'b0;
        hlt      = 1'b0;
        if (ir_low[RR_CLA]) begin
            alu_code = ALU_CLA;
            ac_ld    = 1'b1;
        end else if (ir_low[RR_CLE]) begin
            alu_code = ALU_CLE;
            e_ld     = 1'b1;
        end else if (ir_low[RR_CMA]) begin
            alu_code = ALU_CMA;
            ac_ld    = 1'b1;
        end else if (ir_low[RR_CME]) begin
            alu_code = ALU_CME;
            e_ld     = 1'b1;
        end else if (ir_low[RR_CIR]) begin
            alu_code = ALU_CIR;
            ac_ld    = 1'b1;
            e_ld     = 1'b1;
        end else if (ir_low[RR_CIL]) begin
            alu_code = ALU_CIL;
            ac_ld    = 1'b1;
            e_ld     = 1'b1;
        end else if (ir_low[RR_INC]) begin
            alu_code = ALU_INC;
            ac_ld    = 1'b1;
        end else if (ir_low[RR_SPA]) begin
            alu_code = ALU_SPA;
            skip     = 1'b1;
        end else if (ir_low[RR_SNA]) begin
            alu_code = ALU_SNA;
            skip     = 1'b1;
        end else if (ir_low[RR_SZA]) begin
            alu_code = ALU_SZA;
            skip     = 1'b1;
        end else if (ir_low[RR_SZE]) begin
            alu_code = ALU_SZE;
            skip     = 1'b1;
        end else if (ir_low[RR_HLT]) begin
            hlt      = 1'b1;
        end else begin
            alu_code = ALU_NONE;
        end
    end

endmodule

// File: rtl/mbc_control.sv
// -----------------------------------------------------------------------------
// mbc_control
// Control unit of a 16-bit basic computer: fetches, decodes and sequences
// memory-reference and register-reference instructions against a handshaked
// memory and an external ALU/accumulator.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mem_rdata, mem_ack  memory read data, transfer complete
//   ac, alu_inc         accumulator value, ALU skip-condition flag
//   mem_addr, mem_wdata memory address / write data
//   mem_rd, mem_wr      memory requests
//   alu_code            ALU operation select (1111 = none)
//   ac_ld, e_ld, dr_ld  load strobes
//   pc, halted          program counter, HLT executed
// Configuration: define MBC_INDIRECT_EN to add indirect addressing (INDIR);
// otherwise IR[15] is ignored for opcodes 0-6.
// Requests, address, ALU code and strobes are registered from the next state,
// so every memory state opens with at least one cycle of no request after an
// ack (the request always drops the cycle after an ack is taken). dr_ld and
// mem_wdata follow the current state/inputs because they must coincide with
// the ack cycle and the live accumulator respectively.
// -----------------------------------------------------------------------------
module mbc_control
    import mbc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic [15:0] ac,
    input  logic        alu_inc,
    output logic [11:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [3:0]  alu_code,
    output logic        ac_ld,
    output logic        e_ld,
    output logic        dr_ld,
    output logic [11:0] pc,
    output logic        halted
);

    state_e      state_r, state_s;
    logic [11:0] pc_r, pc_s;
    logic [11:0] ar_r, ar_s;
    logic [15:0] ir_r, ir_s;

    logic        mem_rd_r, mem_wr_r;
    logic [11:0] mem_addr_r;
    logic [3:0]  alu_code_r;
    logic        ac_ld_r, e_ld_r, halted_r;

    logic        rd_s, wr_s;
    logic [11:0] addr_s;
    logic [3:0]  alu_code_s;
    logic        ac_ld_s, e_ld_s, halted_s;

    logic        ack_s;
    logic [2:0]  op_s;

    logic [3:0]  rr_alu_code_s;
    logic        rr_ac_ld_s, rr_e_ld_s, rr_skip_s, rr_hlt_s;

    // An ack only counts while a request is actually being presented
    assign ack_s = mem_ack & (mem_rd_r | mem_wr_r);
    assign op_s  = ir_r[14:12];

    mbc_regref_decode u_regref (
        .ir_low   (ir_r[11:0]),
        .alu_code (rr_alu_code_s),
        .ac_ld    (rr_ac_ld_s),
        .e_ld     (rr_e_ld_s),
        .skip     (rr_skip_s),
        .hlt      (rr_hlt_s)
    );

    // Next-state and datapath register update
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        ar_s    = ar_r;
        ir_s    = ir_r;
        case (state_r)
            ST_FETCH: begin
                if (ack_s) begin
                    ir_s    = mem_rdata;
                    pc_s    = pc_r + 12'd1;
                    state_s = ST_DECODE;
                end else begin
                    state_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                ar_s = ir_r[11:0];
                if (op_s == OP_REG) begin
                    // IR[15]=1 here is an I/O instruction, executed as a NOP
                    state_s = ir_r[15] ? ST_FETCH : ST_REGREF;
`ifdef MBC_INDIRECT_EN
                end else if (ir_r[15]) begin
                    state_s = ST_INDIR;
`endif
                end else begin
                    state_s = mref_next(op_s);
                    if (op_s == OP_BUN) begin
                        pc_s = ir_r[11:0];
                    end else begin
                        pc_s = pc_r;
                    end
                end
            end
`ifdef MBC_INDIRECT_EN
            ST_INDIR: begin
                if (ack_s) begin
                    ar_s    = mem_rdata[11:0];
                    state_s = mref_next(op_s);
                    if (op_s == OP_BUN) begin
                        pc_s = mem_rdata[11:0];
                    end else begin
                        pc_s = pc_r;
                    end
                end else begin
                    state_s = ST_INDIR;
                end
            end
`endif
            ST_OPRD: begin
                if (ack_s) begin
                    state_s = ST_EXEC;
                end else begin
                    state_s = ST_OPRD;
                end
            end
            ST_EXEC: begin
                state_s = ST_FETCH;
            end
            ST_WRITE: begin
                if (ack_s) begin
                    state_s = ST_FETCH;
                    if (op_s == OP_BSA) begin
                        pc_s = ar_r + 12'd1;
                    end else begin
                        pc_s = pc_r;
                    end
                end else begin
                    state_s = ST_WRITE;
                end
            end
            ST_REGREF: begin
                state_s = rr_hlt_s ? ST_HALT : ST_FETCH;
                if (rr_skip_s && alu_inc) begin
                    pc_s = pc_r + 12'd1;
                end else begin
                    pc_s = pc_r;
                end
            end
            ST_HALT: begin
                state_s = ST_HALT;
            end
            default: begin
                state_s = ST_FETCH;
            end
        endcase
    end

    // Output values for the state being entered (registered below)
    always_comb begin
        rd_s       = is_read_state(state_s) && !ack_s;
        wr_s       = (state_s == ST_WRITE) && !ack_s;
        addr_s     = 12'h000;
        alu_code_s = ALU_NONE;
        ac_ld_s    = 1'b0;
        e_ld_s     = 1'b0;
        halted_s   = (state_s == ST_HALT);
        case (state_s)
            ST_FETCH: begin
                addr_s = pc_s;
            end
            ST_INDIR, ST_OPRD, ST_WRITE: begin
                addr_s = ar_s;
            end
            ST_EXEC: begin
                case (op_s)
                    OP_AND: begin
                        alu_code_s = ALU_AND;
                        ac_ld_s    = 1'b1;
                    end
                    OP_ADD: begin
                        alu_code_s = ALU_ADD;
                        ac_ld_s    = 1'b1;
                        e_ld_s     = 1'b1;
                    end
                    OP_LDA: begin
                        alu_code_s = ALU_LDA;
                        ac_ld_s    = 1'b1;
                    end
                    default: begin
                        alu_code_s = ALU_NONE;
                    end
                endcase
            end
            ST_REGREF: begin
                alu_code_s = rr_alu_code_s;
                ac_ld_s    = rr_ac_ld_s;
                e_ld_s     = rr_e_ld_s;
            end
            default: begin
                addr_s = 12'h000;
            end
        endcase
    end

    // State, datapath and output registers; reset also aborts any open handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_FETCH;
            pc_r       <= 12'h000;
            ar_r       <= 12'h000;
            ir_r       <= 16'h0000;
            mem_rd_r   <= 1'b0;
            mem_wr_r   <= 1'b0;
            mem_addr_r <= 12'h000;
            alu_code_r <= ALU_NONE;
            ac_ld_r    <= 1'b0;
            e_ld_r     <= 1'b0;
            halted_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            pc_r       <= pc_s;
            ar_r       <= ar_s;
            ir_r       <= ir_s;
            mem_rd_r   <= rd_s;
            mem_wr_r   <= wr_s;
            mem_addr_r <= addr_s;
            alu_code_r <= alu_code_s;
            ac_ld_r    <= ac_ld_s;
            e_ld_r     <= e_ld_s;
            halted_r   <= halted_s;
        end
    end

    // Write data tracks the live accumulator (STA) or return address (BSA)
    always_comb begin
        mem_wdata = 16'h0000;
        if (state_r == ST_WRITE) begin
            mem_wdata = (op_s == OP_STA) ? ac : {4'h0, pc_r};
        end else begin
            mem_wdata = 16'h0000;
        end
    end

    assign dr_ld    = (state_r == ST_OPRD) && ack_s;
    assign mem_rd   = mem_rd_r;
    assign mem_wr   = mem_wr_r;
    assign mem_addr = mem_addr_r;
    assign alu_code = alu_code_r;
    assign ac_ld    = ac_ld_r;
    assign e_ld     = e_ld_r;
    assign pc       = pc_r;
    assign halted   = halted_r;

endmodule

// File: tb/tb_mbc_control.sv
// -----------------------------------------------------------------------------
// tb_mbc_control
// Scoreboard bench: each scenario loads a small program into a behavioural
// memory and queues the hand-derived sequence of observable events (fetch and
// operand reads, writes, dr_ld pulses, ALU load strobes, halt). A monitor
// thread logs events from the DUT pins and compares them against the queue.
// -----------------------------------------------------------------------------
module tb_mbc_control;

    logic        clk;
    logic        rst;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] ac;
    logic        alu_inc;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [3:0]  alu_code;
    logic        ac_ld;
    logic        e_ld;
    logic        dr_ld;
    logic [11:0] pc;
    logic        halted;

    logic [15:0] mem [0:4095];
    logic [31:0] exp_q [$];
    int          vectors;
    int          miscompares;
    int          wait_cyc;
    int          force_req;
    logic        halt_prev;

    mbc_control dut (
        .clk       (clk),
        .rst       (rst),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .ac        (ac),
        .alu_inc   (alu_inc),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .alu_code  (alu_code),
        .ac_ld     (ac_ld),
        .e_ld      (e_ld),
        .dr_ld     (dr_ld),
        .pc        (pc),
        .halted    (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event encodings: {kind[3:0], field_a[11:0], field_b[15:0]}
    function automatic logic [31:0] ev_rd(input logic [11:0] a);
        return {4'd0, a, 16'h0000};
    endfunction
    function automatic logic [31:0] ev_wr(input logic [11:0] a, input logic [15:0] d);
        return {4'd1, a, d};
    endfunction
    function automatic logic [31:0] ev_alu(input logic [3:0] code, input logic acl, input logic el);
        return {4'd2, 8'h00, code, 14'h0000, acl, el};
    endfunction
    function automatic logic [31:0] ev_dr(input logic [11:0] a);
        return {4'd3, a, 16'h0000};
    endfunction
    function automatic logic [31:0] ev_hlt();
        return {4'd4, 12'h000, 16'h0000};
    endfunction

    // Behavioural memory: acks after wait_cyc cycles of a held request;
    // force_req injects one ack outside any request
    initial begin : mem_model
        int cnt;
        int force_done;
        cnt        = 0;
        force_done = 0;
        mem_ack    = 1'b0;
        mem_rdata  = 16'h0000;
        forever begin
            @(posedge clk);
            #1;
            if (mem_ack) begin
                mem_ack = 1'b0;
                cnt     = 0;
            end else if (force_req != force_done) begin
                force_done = force_req;
                mem_ack    = 1'b1;
                mem_rdata  = 16'h4055;
                cnt        = 0;
            end else if ((mem_rd || mem_wr) && !rst) begin
                if (cnt >= wait_cyc) begin
                    mem_ack   = 1'b1;
                    mem_rdata = mem[mem_addr];
                end else begin
                    cnt = cnt + 1;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic observe(input logic [31:0] ev);
        logic [31:0] e;
        vectors = vectors + 1;
        if (exp_q.size() == 0) begin
            miscompares = miscompares + 1;
            $display("FAIL unexpected_event: got %h expected none", ev);
        end else begin
            e = exp_q.pop_front();
            if (ev !== e) begin
                miscompares = miscompares + 1;
                $display("FAIL event: got %h expected %h", ev, e);
            end
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    endtask

    // Assert reset for two cycles and check the reset state
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_pc", {20'h0, pc}, 32'h0);
        check("rst_strobes", {26'h0, mem_rd, mem_wr, ac_ld, e_ld, dr_ld, halted}, 32'h0);
        check("rst_alu_code", {28'h0, alu_code}, 32'hF);
        @(negedge clk);
    endtask

    // Release reset, run until HLT, then confirm the halt is sticky and quiet
    task automatic run_until_halt(input logic [11:0] exp_pc);
        rst = 1'b0;
        for (int i = 0; i < 3000 && !halted; i++) @(negedge clk);
        check("halt_reached", {31'h0, halted}, 32'h1);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
        check("events_drained", exp_q.size(), 32'h0);
        exp_q.delete();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("halt_hold",
                  {8'h00, halted, mem_rd, mem_wr, ac_ld, e_ld, dr_ld, 2'b00, alu_code, pc},
                  {8'h00, 6'b100000, 2'b00, 4'hF, exp_pc});
        end
    endtask

    initial begin
        rst         = 1'b1;
        ac          = 16'h1234;
        alu_inc     = 1'b1;
        wait_cyc    = 2;
        force_req   = 0;
        vectors     = 0;
        miscompares = 0;
        halt_prev   = 1'b0;

        fork
            begin : monitor
                forever begin
                    @(negedge clk);
                    if (!rst) begin
                        if (mem_ack && mem_rd) observe(ev_rd(mem_addr));
                        if (mem_ack && mem_wr) observe(ev_wr(mem_addr, mem_wdata));
                        if (dr_ld) observe(ev_dr(mem_addr));
                        if (ac_ld || e_ld) observe(ev_alu(alu_code, ac_ld, e_ld));
                        if (halted && !halt_prev) observe(ev_hlt());
                    end
                    halt_prev = halted;
                end
            end
        join_none

        // Scenario A: CLA, ADD, LDA, STA, SPA skip, AND, CMA, INC, CIR, CLE, BUN,
        // priority CLA+CLE, NOP, ISZ, I/O NOP, HLT. Two memory wait cycles.
        do_reset();
        clear_mem();
        mem[12'h000] = 16'h7800; mem[12'h001] = 16'h1010; mem[12'h002] = 16'h2011;
        mem[12'h003] = 16'h3012; mem[12'h004] = 16'h7010; mem[12'h005] = 16'h7001;
        mem[12'h006] = 16'h0013; mem[12'h007] = 16'h7200; mem[12'h008] = 16'h7020;
        mem[12'h009] = 16'h7080; mem[12'h00A] = 16'h7400; mem[12'h00B] = 16'h4020;
        mem[12'h020] = 16'h7C00; mem[12'h021] = 16'h7000; mem[12'h022] = 16'h6030;
        mem[12'h023] = 16'hF800; mem[12'h024] = 16'h7001;
        wait_cyc = 2;
        alu_inc  = 1'b1;
        exp_q.push_back(ev_rd(12'h000)); exp_q.push_back(ev_alu(4'b0110, 1'b1, 1'b0));
        exp_q.push_back(ev_rd(12'h001)); exp_q.push_back(ev_rd(12'h010));
        exp_q.push_back(ev_dr(12'h010)); exp_q.push_back(ev_alu(4'b0001, 1'b1, 1'b1));
        exp_q.push_back(ev_rd(12'h002)); exp_q.push_back(ev_rd(12'h011));
        exp_q.push_back(ev_dr(12'h011)); exp_q.push_back(ev_alu(4'b0010, 1'b1, 1'b0));
        exp_q.push_back(ev_rd(12'h003)); exp_q.push_back(ev_wr(12'h012, 16'h1234));
        exp_q.push_back(ev_rd(12'h004));
        exp_q.push_back(ev_rd(12'h006)); exp_q.push_back(ev_rd(12'h013));
        exp_q.push_back(ev_dr(12'h013)); exp_q.push_back(ev_alu(4'b0000, 1'b1, 1'b0));
        exp_q.push_back(ev_rd(12'h007)); exp_q.push_back(ev_alu(4'b0011, 1'b1, 1'b0));
        exp_q.push_back(ev_rd(12'h008)); exp_q.push_back(ev_alu(4'b0111, 1'b1, 1'b0));
        exp_q.push_back(ev_rd(12'h009)); exp_q.push_back(ev_alu(4'b0100, 1'b1, 1'b1));
        exp_q.push_back(ev_rd(12'h00A)); exp_q.push_back(ev_alu(4'b1000, 1'b0, 1'b1));
        exp_q.push_back(ev_rd(12'h00B));
        exp_q.push_back(ev_rd(12'h020)); exp_q.push_back(ev_alu(4'b0110, 1'b1, 1'b0));
        exp_q.push_back(ev_rd(12'h021)); exp_q.push_back(ev_rd(12'h022));
        exp_q.push_back(ev_rd(12'h023)); exp_q.push_back(ev_rd(12'h024));
        exp_q.push_back(ev_hlt());
        run_until_halt(12'h025);

        // Scenario B: BUN to 0xFFF, BSA with pc wrap, SPA without skip, HLT
        do_reset();
        clear_mem();
        mem[12'h000] = 16'h4FFF; mem[12'hFFF] = 16'h5100;
        mem[12'h101] = 16'h7010; mem[12'h102] = 16'h7001;
        wait_cyc = 0;
        alu_inc  = 1'b0;
        exp_q.push_back(ev_rd(12'h000)); exp_q.push_back(ev_rd(12'hFFF));
        exp_q.push_back(ev_wr(12'h100, 16'h0000));
        exp_q.push_back(ev_rd(12'h101)); exp_q.push_back(ev_rd(12'h102));
        exp_q.push_back(ev_hlt());
        run_until_halt(12'h103);

        // Scenario C: BUN with IR[15]=1
        do_reset();
        clear_mem();
        mem[12'h000] = 16'hC020; mem[12'h020] = 16'h0ABC;
        mem[12'h021] = 16'h7001; mem[12'hABC] = 16'h7001;
        wait_cyc = 1;
        alu_inc  = 1'b1;
        exp_q.push_back(ev_rd(12'h000)); exp_q.push_back(ev_rd(12'h020));
`ifdef MBC_INDIRECT_EN
        exp_q.push_back(ev_rd(12'hABC)); exp_q.push_back(ev_hlt());
        run_until_halt(12'hABD);
`else
        exp_q.push_back(ev_rd(12'hABC)); exp_q.push_back(ev_dr(12'hABC));
        exp_q.push_back(ev_alu(4'b0000, 1'b1, 1'b0));
        exp_q.push_back(ev_rd(12'h021)); exp_q.push_back(ev_hlt());
        run_until_halt(12'h022);
`endif

        // Scenario D: reset during an open fetch, then a late stray ack
        do_reset();
        clear_mem();
        mem[12'h000] = 16'h7001;
        wait_cyc = 100;
        rst = 1'b0;
        for (int i = 0; i < 20 && !mem_rd; i++) @(negedge clk);
        check("abort_rd_open", {31'h0, mem_rd}, 32'h1);
        @(negedge clk);
        rst      = 1'b1;
        wait_cyc = 0;
        force_req = force_req + 1;
        @(negedge clk);
        check("abort_rd_drop", {31'h0, mem_rd}, 32'h0);
        check("abort_pc", {20'h0, pc}, 32'h0);
        exp_q.push_back(ev_rd(12'h000)); exp_q.push_back(ev_hlt());
        run_until_halt(12'h001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
